// File: rtl/fifo_mem_ctrl_if.sv
// Producer/consumer request and memory-control bundle for fifo_mem_ctrl.
// The err_* sticky flags exist only when FIFO_ERR_EN is defined.
interface fifo_mem_ctrl_if #(
  parameter int PTR_WIDTH = 3
);
  logic                 push;
  logic                 pop;
  logic                 write;
  logic                 read;
  logic [PTR_WIDTH-1:0] ptr_write;
  logic [PTR_WIDTH-1:0] ptr_read;
  logic [PTR_WIDTH:0]   count;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic                 valid_out;
`ifdef FIFO_ERR_EN
  logic                 err_overflow;
  logic                 err_underflow;

  modport master (
    output push, pop,
    input  write, read, ptr_write, ptr_read, count, full, empty,
           almost_full, almost_empty, valid_out, err_overflow, err_underflow
  );
  modport slave (
    input  push, pop,
    output write, read, ptr_write, ptr_read, count, full, empty,
           almost_full, almost_empty, valid_out, err_overflow, err_underflow
  );
`else
  modport master (
    output push, pop,
    input  write, read, ptr_write, ptr_read, count, full, empty,
           almost_full, almost_empty, valid_out
  );
  modport slave (
    input  push, pop,
    output write, read, ptr_write, ptr_read, count, full, empty,
           almost_full, almost_empty, valid_out
  );
`endif
endinterface

// File: rtl/fifo_mem_ctrl.sv
// Circular-FIFO pointer/flag controller for a dual-pointer register memory.
// Optional FIFO_ERR_EN adds sticky overflow/underflow flags.
module fifo_mem_ctrl #(
  parameter int LENGTH          = 8,
  parameter int PTR_WIDTH       = 3,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic          clk,
  input  logic          reset,
  fifo_mem_ctrl_if.slave bus
);
  localparam logic [PTR_WIDTH:0] CNT_FULL = (PTR_WIDTH+1)'(LENGTH);
  localparam logic [PTR_WIDTH:0] CNT_AF   = (PTR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [PTR_WIDTH:0] CNT_AE   = (PTR_WIDTH+1)'(ALMOST_EMPTY_TH);

  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [PTR_WIDTH:0]   count;
  logic                 valid_q;
  logic                 full, empty;
  logic                 write_acc, read_acc;

  // Flags come from the registered count only, so they never glitch on push/pop.
  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Gating with reset keeps write/read low while reset is held, even with push high.
  assign write_acc = bus.push & ~full  & reset;
  assign read_acc  = bus.pop  & ~empty & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (write_acc) wr_ptr <= wr_ptr + 1'b1;
      if (read_acc)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({write_acc, read_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      valid_q <= read_acc;
    end
  end

  assign bus.write        = write_acc;
  assign bus.read         = read_acc;
  assign bus.ptr_write    = wr_ptr;
  assign bus.ptr_read     = rd_ptr;
  assign bus.count        = count;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count >= CNT_AF);
  assign bus.almost_empty = (count <= CNT_AE);
  assign bus.valid_out    = valid_q;

`ifdef FIFO_ERR_EN
  logic err_ov, err_un;

  // A dropped request only counts as an error when the other side is not also active.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_ov <= 1'b0;
      err_un <= 1'b0;
    end else begin
      if (bus.push & full  & ~bus.pop)  err_ov <= 1'b1;
      if (bus.pop  & empty & ~bus.push) err_un <= 1'b1;
    end
  end

  assign bus.err_overflow  = err_ov;
  assign bus.err_underflow = err_un;
`endif
endmodule
